reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Power-on/system reset sequencer. Releases N_STAGES downstream reset domains one after another: a long first delay, then a fixed gap between each later stage.
- Adds four things over a single-output reset delay:
  - asynchronous active-low system reset with synchronised deassertion;
  - a lock qualifier, such as PLL locked;
  - a software restart request;
  - status outputs.
- Sits at the top level between the board clock/reset and every block needing staged reset release (e.g. LCD controller after SDRAM after PLL).

Parameters:
- CNT_W, 20: delay counter width.
- N_STAGES, 3: number of staged reset outputs; must be 1 or more.
- FIRST_DLY, 20'hFFFFF: counting cycles before stage 0 releases. Range 1 to 2^CNT_W-1.
- STAGE_DLY, 16'hFFFF: counting cycles between stage k-1 and stage k release. Range 1 to 2^CNT_W-1.
- SYNC_STAGES, 2: flops in the reset deassertion synchroniser; must be 2 or more.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iLOCK  in  1  clock-good qualifier; counting advances only while 1.
- iRESTART  in  1  synchronous restart request, active-high, level or pulse.
- oRESET  out  N_STAGES  per-domain release; 0 = domain held in reset, 1 = released. Bit 0 releases first.
- oSTAGE  out  $clog2(N_STAGES+1)  number of stages currently released.
- oDONE  out  1  1 when all stages are released.

Behaviour:
- iRST_N low:
  - asynchronously forces oRESET=0, oSTAGE=0, oDONE=0, counter=0, state=FIRST, synchroniser chain=0;
  - no dependence on iCLK.
- iRST_N deassertion:
  - passes through the SYNC_STAGES-flop synchroniser;
  - the internal reset releases after the SYNC_STAGES-th rising edge at which iRST_N is sampled high;
  - edge 1 is the first such edge.
- Counter: CNT_W bits, unsigned.
  - Increments by 1 on each edge where the core is out of reset, iLOCK=1 and iRESTART=0.
  - Clears to 0 on each stage release.
  - Never wraps.
- FSM states: FIRST, STEP, DONE.
  - FIRST: when cnt==FIRST_DLY-1 and counting is enabled, next edge sets oRESET[0]=1, cnt=0, oSTAGE=1. Goes to DONE if N_STAGES==1, otherwise STEP.
  - STEP: when cnt==STAGE_DLY-1 and counting is enabled, next edge sets oRESET[oSTAGE]=1, cnt=0, oSTAGE+=1. Goes to DONE on the edge the last bit sets.
  - DONE: holds all outputs; counter idle.
- Timing with iLOCK=1 throughout:
  - oRESET[0] rises at edge SYNC_STAGES+FIRST_DLY;
  - oRESET[k] rises STAGE_DLY edges after oRESET[k-1].
- oRESET bits only ever go 0 to 1 in ascending index order. Release is thermometer-coded: oRESET == (1<<oSTAGE)-1 at all times.
- oDONE is registered; it rises on the same edge as oRESET[N_STAGES-1] and equals (oSTAGE==N_STAGES).
- Restart: if iRESTART=1 or iLOCK=0 is sampled at edge e, in any state:
  - at edge e, oRESET=0, oSTAGE=0, oDONE=0, cnt=0, state=FIRST;
  - the full sequence reruns from counting edge e+1, once both conditions clear.
- Restart priority: restart/lock-loss beats a stage release on the same edge; the release does not happen.
- iLOCK low during FIRST/STEP: outputs already released drop to 0 (full restart), not a pause.
- iRESTART held high: sequence stays in FIRST with counter 0.
- iRST_N asserted mid-sequence: immediate asynchronous clear, as above.
- No combinational path from any input to any output. All outputs are registered, except the asynchronous clear.

Decomposition:
- Shared package reset_pkg holds:
  - state enum (FIRST, STEP, DONE);
  - default constants DEF_FIRST_DLY and DEF_STAGE_DLY;
  - a parameter-check function (delay ranges and N_STAGES>=1) used by elaboration-time asserts.
- One sub-module: reset_sync, parameter SYNC_STAGES.
  - Asynchronous-assert/synchronous-deassert flop chain.
  - Ports iCLK, iRST_N, oRST_N.
  - Reusable by other domains.

Test Plan:
- Bench parameters: CNT_W=8, N_STAGES=3, FIRST_DLY=8, STAGE_DLY=4, SYNC_STAGES=2, iLOCK=1.
- Power-up: release iRST_N -> oRESET=000 through edge 9; 001 at edge 10, 011 at edge 14, 111 at edge 18; oSTAGE 1,2,3 at those edges; oDONE=1 at edge 18 and stays.
- Lock gating: iLOCK=0 for edges 5-20 after reset release -> all outputs 0; once iLOCK returns high, sampled high from edge 21 -> oRESET[0] rises at edge 28 (21+FIRST_DLY-1).
- Restart after DONE: single-cycle iRESTART at edge e -> oRESET=000 and oDONE=0 at edge e; 001 at e+8, 011 at e+12, 111 at e+16.
- Collision: iRESTART asserted on the edge where oRESET[1] would set (edge 14) -> oRESET=000 at edge 14, not 011; oRESET[0] re-rises at edge 22.
- Asynchronous reset mid-STEP: iRST_N low between clock edges at edge 12.5 -> outputs 0 before edge 13; release and rerun from the beginning gives the power-up timing.
- Random iLOCK/iRESTART over 10k cycles with assertions checking:
  - oRESET is always thermometer-coded and equal to (1<<oSTAGE)-1;
  - oDONE == (oSTAGE==3);
  - the inter-release gap is never less than STAGE_DLY.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types, default delays and parameter sanity check for the
// staged reset sequencer.
package reset_pkg;

   typedef enum logic [1:0] {
      ST_FIRST,
      ST_STEP,
      ST_DONE
   } state_e;

   localparam int unsigned DEF_FIRST_DLY = 32'h000F_FFFF;
   localparam int unsigned DEF_STAGE_DLY = 32'h0000_FFFF;

   function automatic bit params_ok(
      input int     cnt_w,
      input int     n_stages,
      input longint first_dly,
      input longint stage_dly
   );
      longint max_dly;
      if (cnt_w < 1 || cnt_w > 32) return 1'b0;
      max_dly = (longint'(1) << cnt_w) - 1;
      return (n_stages >= 1)
          && (first_dly >= 1) && (first_dly <= max_dly)
          && (stage_dly >= 1) && (stage_dly <= max_dly);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
// Output follows iRST_N low at once and rises SYNC_STAGES edges later.
module reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic iCLK,
   input  logic iRST_N,
   output logic oRST_N
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("reset_sync: SYNC_STAGES must be 2 or more");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign oRST_N = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: long first delay, then a fixed gap per stage.
// Lock loss or a restart request clears everything and reruns.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int          CNT_W       = 20,
   parameter int          N_STAGES    = 3,
   parameter int unsigned FIRST_DLY   = DEF_FIRST_DLY,
   parameter int unsigned STAGE_DLY   = DEF_STAGE_DLY,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                              iCLK,
   input  logic                              iRST_N,
   input  logic                              iLOCK,
   input  logic                              iRESTART,
   output logic [N_STAGES-1:0]               oRESET,
   output logic [$clog2(N_STAGES+1)-1:0]     oSTAGE,
   output logic                              oDONE
);

   localparam int STW = $clog2(N_STAGES + 1);

   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_DLY - 1);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STAGE_DLY - 1);
   localparam logic [STW-1:0]   PEN_STAGE  = STW'(N_STAGES - 1);

   if (!params_ok(CNT_W, N_STAGES, longint'(FIRST_DLY),
                  longint'(STAGE_DLY))) begin : g_bad_param
      $error("reset_sequencer: delay or stage parameters out of range");
   end

   logic rst_core_n;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .oRST_N(rst_core_n)
   );

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [STW-1:0]        stage_q, stage_d;
   logic [N_STAGES-1:0]   rel_q,   rel_d;
   logic                  done_q,  done_d;
   logic                  hit;

   always_ff @(posedge iCLK or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q <= ST_FIRST;
         cnt_q   <= '0;
         stage_q <= '0;
         rel_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         rel_q   <= rel_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rel_d   = rel_q;
      done_d  = done_q;
      hit     = 1'b0;

      // Lock loss and restart win over any release on the same edge
      if (iRESTART || !iLOCK) begin
         state_d = ST_FIRST;
         cnt_d   = '0;
         stage_d = '0;
         rel_d   = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_FIRST: hit = (cnt_q == FIRST_LAST);
            ST_STEP:  hit = (cnt_q == STEP_LAST);
            default:  hit = 1'b0;
         endcase

         if (hit) begin
            rel_d   = rel_q | (N_STAGES'(1) << stage_q);
            stage_d = stage_q + 1'b1;
            cnt_d   = '0;
            done_d  = (stage_q == PEN_STAGE);
            state_d = done_d ? ST_DONE : ST_STEP;
         end else if (state_q != ST_DONE && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign oRESET = rel_q;
   assign oSTAGE = stage_q;
   assign oDONE  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: scripted scenarios with a per-edge
// expectation queue, plus a long random run with invariant checks.
module tb_reset_sequencer;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iLOCK = 1'b1;
   logic       iRESTART = 1'b0;
   logic [2:0] oRESET;
   logic [1:0] oSTAGE;
   logic       oDONE;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] rst;
      logic [1:0] stg;
      logic       done;
   } exp_t;

   exp_t sb[$];

   always #5 iCLK = ~iCLK;

   reset_sequencer #(
      .CNT_W      (8),
      .N_STAGES   (3),
      .FIRST_DLY  (8),
      .STAGE_DLY  (4),
      .SYNC_STAGES(2)
   ) dut (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iLOCK   (iLOCK),
      .iRESTART(iRESTART),
      .oRESET  (oRESET),
      .oSTAGE  (oSTAGE),
      .oDONE   (oDONE)
   );

   // k = counting edges since the sequence (re)started
   function automatic exp_t model(input int k);
      exp_t e;
      int   s;
      s = (k >= 16) ? 3 : (k >= 12) ? 2 : (k >= 8) ? 1 : 0;
      e.stg  = 2'(s);
      e.rst  = 3'((1 << s) - 1);
      e.done = (s == 3);
      return e;
   endfunction

   // Holds reset, then releases on a falling edge: next posedge is edge 1
   task automatic hold_reset();
      iRST_N   = 1'b0;
      iLOCK    = 1'b1;
      iRESTART = 1'b0;
      sb.delete();
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      iRST_N = 1'b1;
   endtask

   task automatic test_reset();
      iLOCK    = 1'b1;
      iRESTART = 1'b0;
      iRST_N   = 1'b0;
      #1;
      checks++;
      if ({oRESET, oSTAGE, oDONE} !== 6'b0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=000000",
                  {oRESET, oSTAGE, oDONE});
      end
      for (int n = 0; n < 4; n++) begin
         @(posedge iCLK);
         #1;
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== 6'b0) begin
            failures++;
            $display("FAIL reset_hold n=%0d got=%b exp=000000",
                     n, {oRESET, oSTAGE, oDONE});
         end
      end
   endtask

   task automatic test_powerup();
      exp_t e;
      hold_reset();
      for (int n = 1; n <= 22; n++) sb.push_back(model(n - 2));
      for (int n = 1; n <= 22; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL powerup edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
      end
   endtask

   task automatic test_lock_gating();
      exp_t e;
      hold_reset();
      for (int n = 1; n <= 32; n++) begin
         if (n < 5)        sb.push_back(model(n - 2));
         else if (n <= 20) sb.push_back(model(-1));
         else              sb.push_back(model(n - 20));
      end
      for (int n = 1; n <= 32; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL lock_gating edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
         if (n == 4)  iLOCK = 1'b0;
         if (n == 20) iLOCK = 1'b1;
      end
   endtask

   task automatic test_restart_after_done();
      exp_t e;
      hold_reset();
      for (int n = 1; n <= 40; n++) begin
         if (n < 21) sb.push_back(model(n - 2));
         else        sb.push_back(model(n - 21));
      end
      for (int n = 1; n <= 40; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL restart_done edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
         if (n == 20) iRESTART = 1'b1;
         if (n == 21) iRESTART = 1'b0;
      end
   endtask

   task automatic test_collision();
      exp_t e;
      hold_reset();
      for (int n = 1; n <= 26; n++) begin
         if (n < 14) sb.push_back(model(n - 2));
         else        sb.push_back(model(n - 14));
      end
      for (int n = 1; n <= 26; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL collision edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
         if (n == 13) iRESTART = 1'b1;
         if (n == 14) iRESTART = 1'b0;
      end
   endtask

   task automatic test_async_mid_step();
      exp_t e;
      hold_reset();
      for (int n = 1; n <= 12; n++) sb.push_back(model(n - 2));
      for (int n = 1; n <= 12; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL async_pre edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
      end
      #4;
      iRST_N = 1'b0;
      #1;
      checks++;
      if ({oRESET, oSTAGE, oDONE} !== 6'b0) begin
         failures++;
         $display("FAIL async_clear got=%b exp=000000",
                  {oRESET, oSTAGE, oDONE});
      end
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST_N = 1'b1;
      for (int n = 1; n <= 20; n++) sb.push_back(model(n - 2));
      for (int n = 1; n <= 20; n++) begin
         @(posedge iCLK);
         #1;
         e = sb.pop_front();
         checks++;
         if ({oRESET, oSTAGE, oDONE} !== e) begin
            failures++;
            $display("FAIL async_rerun edge=%0d got rst=%b stg=%0d done=%b exp rst=%b stg=%0d done=%b",
                     n, oRESET, oSTAGE, oDONE, e.rst, e.stg, e.done);
         end
      end
   endtask

   task automatic test_random();
      int       last_rel;
      logic [1:0] prev_stg;
      logic [2:0] therm;
      hold_reset();
      last_rel = 0;
      prev_stg = 2'd0;
      for (int cyc = 1; cyc <= 10000; cyc++) begin
         @(posedge iCLK);
         #1;
         therm = 3'((1 << oSTAGE) - 1);
         checks++;
         if (oRESET !== therm) begin
            failures++;
            $display("FAIL rand_therm cyc=%0d got rst=%b stg=%0d exp rst=%b",
                     cyc, oRESET, oSTAGE, therm);
         end
         checks++;
         if (oDONE !== (oSTAGE == 2'd3)) begin
            failures++;
            $display("FAIL rand_done cyc=%0d got done=%b stg=%0d",
                     cyc, oDONE, oSTAGE);
         end
         if (oSTAGE > prev_stg) begin
            checks++;
            if (oSTAGE != prev_stg + 2'd1) begin
               failures++;
               $display("FAIL rand_step cyc=%0d got stg=%0d prev=%0d",
                        cyc, oSTAGE, prev_stg);
            end
            if (prev_stg != 2'd0) begin
               checks++;
               if (cyc - last_rel < 4) begin
                  failures++;
                  $display("FAIL rand_gap cyc=%0d got gap=%0d exp>=4",
                           cyc, cyc - last_rel);
               end
            end
            last_rel = cyc;
         end else if (oSTAGE < prev_stg) begin
            checks++;
            if (oSTAGE !== 2'd0) begin
               failures++;
               $display("FAIL rand_drop cyc=%0d got stg=%0d exp=0",
                        cyc, oSTAGE);
            end
         end
         prev_stg = oSTAGE;
         iLOCK    = ($urandom_range(0, 63) != 0);
         iRESTART = ($urandom_range(0, 127) == 0);
      end
      iLOCK    = 1'b1;
      iRESTART = 1'b0;
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_lock_gating();
      test_restart_after_done();
      test_collision();
      test_async_mid_step();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
